// File: rtl/adc_pulse_sampler.sv
// Conversion controller for an 8-bit parallel ADC: drives CS/RD/WR, waits on INTR, captures at a fixed rate.
// Define ADC_AVG_EN to compile in a 4-tap boxcar filter on the captured samples.
module adc_pulse_sampler #(
  parameter int SAMPLE_DIV     = 100000,
  parameter int WR_LOW_CYCLES  = 5,
  parameter int RD_CYCLES      = 5,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [7:0] adc_data,
  input  logic       adc_intr_n,
  output logic       adc_cs_n,
  output logic       adc_rd_n,
  output logic       adc_wr_n,
  output logic [7:0] sample,
  output logic       sample_valid,
  output logic       adc_timeout
);

  localparam int BLANK_CYCLES = 3;
  localparam int MAX_A = (WR_LOW_CYCLES > RD_CYCLES) ? WR_LOW_CYCLES : RD_CYCLES;
  localparam int MAX_B = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int MAX_C = (MAX_B > 4) ? MAX_B : 4;
  localparam int CW = $clog2(MAX_C + 1);
  localparam int PW = $clog2(SAMPLE_DIV);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic          intr_meta;
  logic          intr_s;
  logic [PW-1:0] period_cnt;
  logic          tick;
  logic          pending;
  logic [2:0]    state;
  logic [2:0]    state_nx;
  logic [CW-1:0] state_cnt;
  logic [CW-1:0] cnt_nx;
  logic          armed;
  logic          timeout_set;
  logic          capture;
  logic          done;
  logic [7:0]    raw_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      intr_meta <= 1'b1;
      intr_s    <= 1'b1;
    end else begin
      intr_meta <= adc_intr_n;
      intr_s    <= intr_meta;
    end
  end

  assign tick = enable && (period_cnt == PW'(SAMPLE_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_cnt <= '0;
    end else if (!enable || tick) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + PW'(1);
    end
  end

  // A new tick wins over IDLE consuming the previous one; a tick onto a set flag is simply absorbed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= 1'b0;
    end else if (!enable) begin
      pending <= 1'b0;
    end else if (tick) begin
      pending <= 1'b1;
    end else if (state == S_IDLE) begin
      pending <= 1'b0;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = state_cnt;
    timeout_set = 1'b0;
    capture     = 1'b0;
    done        = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_nx = '0;
        if (pending && enable) state_nx = S_START;
      end
      S_START: begin
        if (state_cnt == CW'(WR_LOW_CYCLES - 1)) begin
          state_nx = S_WAIT;
          cnt_nx   = '0;
        end else begin
          cnt_nx = state_cnt + CW'(1);
        end
      end
      S_WAIT: begin
        // INTR must be seen high inside WAIT before a low counts, so a stale low never triggers a read.
        if (state_cnt >= CW'(BLANK_CYCLES) && armed && !intr_s) begin
          state_nx = S_READ;
          cnt_nx   = '0;
        end else if (state_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          state_nx    = S_IDLE;
          cnt_nx      = '0;
          timeout_set = 1'b1;
        end else begin
          cnt_nx = state_cnt + CW'(1);
        end
      end
      S_READ: begin
        if (state_cnt == CW'(RD_CYCLES - 1)) begin
          state_nx = S_DONE;
          cnt_nx   = '0;
          capture  = 1'b1;
        end else begin
          cnt_nx = state_cnt + CW'(1);
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
        done     = 1'b1;
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Strobes are registered from the next state so they switch on the same edge as the state itself.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      state_cnt   <= '0;
      armed       <= 1'b0;
      adc_cs_n    <= 1'b1;
      adc_wr_n    <= 1'b1;
      adc_rd_n    <= 1'b1;
      raw_q       <= 8'h00;
      adc_timeout <= 1'b0;
    end else begin
      state     <= state_nx;
      state_cnt <= cnt_nx;
      if (state != S_WAIT) begin
        armed <= 1'b0;
      end else if (intr_s) begin
        armed <= 1'b1;
      end
      adc_cs_n <= !((state_nx == S_START) || (state_nx == S_READ));
      adc_wr_n <= (state_nx != S_START);
      adc_rd_n <= (state_nx != S_READ);
      if (capture) raw_q <= adc_data;
      if (timeout_set) begin
        adc_timeout <= 1'b1;
      end else if (done) begin
        adc_timeout <= 1'b0;
      end
    end
  end

`ifdef ADC_AVG_EN
  logic [7:0] hist0;
  logic [7:0] hist1;
  logic [7:0] hist2;
  logic [7:0] avg_q;
  logic       avg_valid;
  logic [9:0] sum_c;

  assign sum_c = {2'b00, raw_q} + {2'b00, hist0} + {2'b00, hist1} + {2'b00, hist2};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist0        <= 8'h00;
      hist1        <= 8'h00;
      hist2        <= 8'h00;
      avg_q        <= 8'h00;
      avg_valid    <= 1'b0;
      sample       <= 8'h00;
      sample_valid <= 1'b0;
    end else begin
      avg_valid <= done;
      if (done) begin
        hist0 <= raw_q;
        hist1 <= hist0;
        hist2 <= hist1;
        avg_q <= 8'(sum_c >> 2);
      end
      sample_valid <= avg_valid;
      if (avg_valid) sample <= avg_q;
    end
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample       <= 8'h00;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= done;
      if (done) sample <= raw_q;
    end
  end
`endif

endmodule

// File: tb/tb_adc_pulse_sampler.sv
// Directed bench for adc_pulse_sampler with a simple ADC response model.
// Expected samples track ADC_AVG_EN so the bench fits either build.
module tb_adc_pulse_sampler;

  localparam int SAMPLE_DIV = 200;
  localparam int WR_LOW     = 5;
  localparam int RD_LEN     = 5;
  localparam int TIMEOUT    = 100;
`ifdef ADC_AVG_EN
  localparam int VLAT = 2;
`else
  localparam int VLAT = 1;
`endif

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic [7:0] adc_data;
  logic       adc_intr_n;
  logic       adc_cs_n;
  logic       adc_rd_n;
  logic       adc_wr_n;
  logic [7:0] sample;
  logic       sample_valid;
  logic       adc_timeout;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int wr_starts = 0;
  int wr_rise_cnt = 0;
  int wr_len = 0;
  int last_wr_len = 0;
  int wr_rise_cyc = 0;
  int rd_starts = 0;
  int rd_len = 0;
  int last_rd_len = 0;
  int rd_fall_cyc = 0;
  int rd_rise_cyc = 0;
  int valid_cnt = 0;
  int valid_cyc = 0;
  int overlap_cnt = 0;
  int intr_fall_cyc = 0;
  logic prev_wr = 1'b1;
  logic prev_rd = 1'b1;
  logic prev_intr = 1'b1;

  int adc_mode = 0;
  int intr_delay = 40;
  logic [7:0] model_data = 8'h00;
  logic [7:0] hist [3];

  adc_pulse_sampler #(
    .SAMPLE_DIV(SAMPLE_DIV),
    .WR_LOW_CYCLES(WR_LOW),
    .RD_CYCLES(RD_LEN),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .adc_data(adc_data),
    .adc_intr_n(adc_intr_n),
    .adc_cs_n(adc_cs_n),
    .adc_rd_n(adc_rd_n),
    .adc_wr_n(adc_wr_n),
    .sample(sample),
    .sample_valid(sample_valid),
    .adc_timeout(adc_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge and pulse bookkeeping, sampled just after each falling clock edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (prev_wr && !adc_wr_n) begin wr_starts++; wr_len = 0; end
      if (!adc_wr_n) wr_len++;
      if (!prev_wr && adc_wr_n) begin last_wr_len = wr_len; wr_rise_cyc = cyc; wr_rise_cnt++; end
      if (prev_rd && !adc_rd_n) begin rd_starts++; rd_len = 0; rd_fall_cyc = cyc; end
      if (!adc_rd_n) rd_len++;
      if (!prev_rd && adc_rd_n) begin last_rd_len = rd_len; rd_rise_cyc = cyc; end
      if (prev_intr && !adc_intr_n) intr_fall_cyc = cyc;
      if (sample_valid) begin valid_cnt++; valid_cyc = cyc; end
      if (!adc_wr_n && !adc_rd_n) overlap_cnt++;
      prev_wr = adc_wr_n;
      prev_rd = adc_rd_n;
      prev_intr = adc_intr_n;
    end
  end

  // ADC model: INTR falls intr_delay cycles after WR rises, returns high once RD is seen low.
  initial begin
    forever begin
      @(negedge adc_wr_n);
      @(posedge adc_wr_n);
      if (adc_mode == 1) begin
        repeat (intr_delay) @(negedge clk);
        adc_data = model_data;
        adc_intr_n = 1'b0;
        for (int i = 0; i < 200 && adc_rd_n; i++) @(negedge clk);
        adc_intr_n = 1'b1;
        for (int i = 0; i < 20 && !adc_rd_n; i++) @(negedge clk);
        adc_data = 8'h3C;
      end
    end
  end

  function automatic logic [7:0] push_capture(input logic [7:0] raw);
    logic [9:0] s;
    s = {2'b00, raw} + {2'b00, hist[0]} + {2'b00, hist[1]} + {2'b00, hist[2]};
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = raw;
`ifdef ADC_AVG_EN
    return s[9:2];
`else
    return raw;
`endif
  endfunction

  function automatic int event_count(input int which);
    case (which)
      0: return valid_cnt;
      1: return wr_rise_cnt;
      2: return wr_starts;
      3: return rd_starts;
      default: return adc_timeout ? 1 : 0;
    endcase
  endfunction

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_event(input int which, input int budget, output bit ok);
    int start;
    start = event_count(which);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      if (event_count(which) != start) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    step();
    checks++; if (adc_cs_n !== 1'b1) begin errors++; $display("[TB] FAIL reset_cs_n got %b want 1", adc_cs_n); end
    checks++; if (adc_rd_n !== 1'b1) begin errors++; $display("[TB] FAIL reset_rd_n got %b want 1", adc_rd_n); end
    checks++; if (adc_wr_n !== 1'b1) begin errors++; $display("[TB] FAIL reset_wr_n got %b want 1", adc_wr_n); end
    checks++; if (sample !== 8'h00) begin errors++; $display("[TB] FAIL reset_sample got %h want 00", sample); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", sample_valid); end
    checks++; if (adc_timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout got %b want 0", adc_timeout); end
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_nominal();
    bit ok;
    int t0;
    logic [7:0] exp;
    adc_mode = 1; intr_delay = 40; model_data = 8'hA5; enable = 1'b1;
    wait_event(0, 500, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL nominal_first_valid got none want pulse"); end
    exp = push_capture(8'hA5);
    checks++; if (sample !== exp) begin errors++; $display("[TB] FAIL nominal_sample got %h want %h", sample, exp); end
    checks++; if (last_wr_len != WR_LOW) begin errors++; $display("[TB] FAIL nominal_wr_len got %0d want %0d", last_wr_len, WR_LOW); end
    checks++; if (last_rd_len != RD_LEN) begin errors++; $display("[TB] FAIL nominal_rd_len got %0d want %0d", last_rd_len, RD_LEN); end
    checks++; if (rd_fall_cyc - intr_fall_cyc != 3) begin errors++; $display("[TB] FAIL nominal_intr_to_rd got %0d want 3", rd_fall_cyc - intr_fall_cyc); end
    checks++; if (valid_cyc - rd_rise_cyc != VLAT) begin errors++; $display("[TB] FAIL nominal_rd_to_valid got %0d want %0d", valid_cyc - rd_rise_cyc, VLAT); end
    checks++; if (adc_timeout !== 1'b0) begin errors++; $display("[TB] FAIL nominal_timeout got %b want 0", adc_timeout); end
    t0 = valid_cyc;
    step();
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("[TB] FAIL nominal_valid_width got %b want 0", sample_valid); end
    wait_event(0, 250, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL nominal_second_valid got none want pulse"); end
    exp = push_capture(8'hA5);
    checks++; if (valid_cyc - t0 != SAMPLE_DIV) begin errors++; $display("[TB] FAIL nominal_period got %0d want %0d", valid_cyc - t0, SAMPLE_DIV); end
    checks++; if (sample !== exp) begin errors++; $display("[TB] FAIL nominal_sample2 got %h want %h", sample, exp); end
  endtask

  task automatic test_timeout();
    bit ok;
    int t0;
    int v0;
    logic [7:0] exp;
    adc_mode = 2;
    wait_event(1, 250, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL timeout_wr_rise got none want edge"); end
    t0 = wr_rise_cyc;
    v0 = valid_cnt;
    wait_event(4, 150, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL timeout_flag got 0 want 1"); end
    checks++; if (cyc - t0 != TIMEOUT) begin errors++; $display("[TB] FAIL timeout_delay got %0d want %0d", cyc - t0, TIMEOUT); end
    checks++; if (valid_cnt != v0) begin errors++; $display("[TB] FAIL timeout_no_valid got %0d want %0d", valid_cnt, v0); end
    adc_mode = 1; model_data = 8'h10;
    wait_event(2, 250, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL timeout_fresh_wr got none want pulse"); end
    wait_event(0, 200, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL timeout_recover_valid got none want pulse"); end
    exp = push_capture(8'h10);
    checks++; if (sample !== exp) begin errors++; $display("[TB] FAIL timeout_recover_sample got %h want %h", sample, exp); end
    checks++; if (adc_timeout !== 1'b0) begin errors++; $display("[TB] FAIL timeout_cleared got %b want 0", adc_timeout); end
  endtask

  task automatic test_enable_drop();
    bit ok;
    int v0;
    int w0;
    logic [7:0] exp;
    model_data = 8'h5E;
    wait_event(1, 250, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL endrop_wr_rise got none want edge"); end
    v0 = valid_cnt;
    repeat (10) step();
    enable = 1'b0;
    wait_event(0, 100, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL endrop_valid got none want pulse"); end
    exp = push_capture(8'h5E);
    checks++; if (sample !== exp) begin errors++; $display("[TB] FAIL endrop_sample got %h want %h", sample, exp); end
    w0 = wr_starts;
    repeat (1000) step();
    checks++; if (wr_starts != w0) begin errors++; $display("[TB] FAIL endrop_no_wr got %0d want %0d", wr_starts - w0, 0); end
    checks++; if (valid_cnt - v0 != 1) begin errors++; $display("[TB] FAIL endrop_valid_count got %0d want 1", valid_cnt - v0); end
    enable = 1'b1;
  endtask

  task automatic test_stale_intr();
    bit ok;
    int t0;
    int r0;
    logic [7:0] exp;
    adc_mode = 0; adc_intr_n = 1'b0; adc_data = 8'h77;
    wait_event(1, 300, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL stale_wr_rise got none want edge"); end
    t0 = wr_rise_cyc;
    r0 = rd_starts;
    wait_event(4, 150, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL stale_timeout got 0 want 1"); end
    checks++; if (cyc - t0 != TIMEOUT) begin errors++; $display("[TB] FAIL stale_timeout_delay got %0d want %0d", cyc - t0, TIMEOUT); end
    checks++; if (rd_starts != r0) begin errors++; $display("[TB] FAIL stale_no_rd got %0d want 0", rd_starts - r0); end
    wait_event(1, 250, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL stale_second_wr got none want edge"); end
    repeat (20) step();
    adc_intr_n = 1'b1;
    repeat (5) step();
    adc_intr_n = 1'b0;
    wait_event(3, 20, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL stale_rearmed_rd got none want pulse"); end
    adc_intr_n = 1'b1;
    wait_event(0, 20, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL stale_valid got none want pulse"); end
    exp = push_capture(8'h77);
    checks++; if (sample !== exp) begin errors++; $display("[TB] FAIL stale_sample got %h want %h", sample, exp); end
    checks++; if (adc_timeout !== 1'b0) begin errors++; $display("[TB] FAIL stale_timeout_clear got %b want 0", adc_timeout); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int v0;
    adc_mode = 1; intr_delay = 40; model_data = 8'hC3;
    wait_event(3, 300, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL rstmid_rd got none want pulse"); end
    step();
    step();
    reset_n = 1'b0;
    #1;
    checks++; if (adc_cs_n !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_cs_n got %b want 1", adc_cs_n); end
    checks++; if (adc_rd_n !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_rd_n got %b want 1", adc_rd_n); end
    checks++; if (adc_wr_n !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_wr_n got %b want 1", adc_wr_n); end
    checks++; if (sample !== 8'h00) begin errors++; $display("[TB] FAIL rstmid_sample got %h want 00", sample); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_valid got %b want 0", sample_valid); end
    hist[0] = 8'h00; hist[1] = 8'h00; hist[2] = 8'h00;
    repeat (3) step();
    reset_n = 1'b1;
    v0 = valid_cnt;
    repeat (30) step();
    checks++; if (valid_cnt != v0) begin errors++; $display("[TB] FAIL rstmid_no_valid got %0d want 0", valid_cnt - v0); end
    checks++; if (sample !== 8'h00) begin errors++; $display("[TB] FAIL rstmid_sample_hold got %h want 00", sample); end
  endtask

  task automatic test_sequence();
    bit ok;
    logic [7:0] raw_tab [4];
    logic [7:0] want_tab [4];
    raw_tab = '{8'h40, 8'h80, 8'hC0, 8'hFF};
`ifdef ADC_AVG_EN
    want_tab = '{8'h10, 8'h30, 8'h60, 8'h9F};
`else
    want_tab = '{8'h40, 8'h80, 8'hC0, 8'hFF};
`endif
    for (int i = 0; i < 4; i++) begin
      model_data = raw_tab[i];
      wait_event(0, 450, ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL seq_valid_%0d got none want pulse", i); end
      checks++; if (sample !== want_tab[i]) begin errors++; $display("[TB] FAIL seq_sample_%0d got %h want %h", i, sample, want_tab[i]); end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    enable = 1'b0;
    adc_data = 8'h3C;
    adc_intr_n = 1'b1;
    hist[0] = 8'h00; hist[1] = 8'h00; hist[2] = 8'h00;
    test_reset();
    test_nominal();
    test_timeout();
    test_enable_drop();
    test_stale_intr();
    test_reset_mid();
    test_sequence();
    checks++; if (overlap_cnt != 0) begin errors++; $display("[TB] FAIL wr_rd_overlap got %0d want 0", overlap_cnt); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
